// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {RUN, MEM_WAIT} mem_state_t;

  localparam int          REG_AW = 5;
  localparam [REG_AW-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: request handshake, freeze generation,
// bounded wait with a sticky timeout error.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_macc,
  input  logic i_dmem_ready,
  output logic o_dmem_req,
  output logic o_freeze,
  output logic o_mem_err
);

  localparam int TW = $clog2(MEM_TIMEOUT);

  mem_state_t      r_state, w_state_next;
  logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt_next;
  logic            r_mem_err, w_mem_err_next;
  logic            w_timeout;

  assign w_timeout  = (r_state == MEM_WAIT) && (r_tmo_cnt == TW'(MEM_TIMEOUT - 1));
  assign o_dmem_req = i_macc & rst;
  // The last permitted wait cycle is released even without ready.
  assign o_freeze   = rst & i_macc & ~i_dmem_ready & ~w_timeout;
  assign o_mem_err  = r_mem_err;

  always_comb begin
    w_state_next   = r_state;
    w_tmo_cnt_next = r_tmo_cnt;
    w_mem_err_next = r_mem_err;
    case (r_state)
      RUN: begin
        if (i_macc && !i_dmem_ready) begin
          w_state_next   = MEM_WAIT;
          w_tmo_cnt_next = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ready) begin
          w_state_next = RUN;
        end else if (w_timeout) begin
          w_state_next   = RUN;
          w_mem_err_next = 1'b1;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + TW'(1);
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_tmo_cnt <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tmo_cnt <= w_tmo_cnt_next;
      r_mem_err <= w_mem_err_next;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stage-register sequencer: load-use, taken-branch and memory-wait
// hazards resolved into per-stage enable/flush, plus a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_id_ars1,
  input  logic [REG_AW-1:0] i_id_ars2,
  input  logic [REG_AW-1:0] i_ex_ard,
  input  logic              i_ex_memtoreg,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_branch_taken,
  input  logic              i_mem_memwrite,
  input  logic              i_mem_memtoreg,
  input  logic              i_dmem_ready,
  output logic              o_dmem_req,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_idex_en,
  output logic              o_exmem_en,
  output logic              o_memwb_en,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_memwb_flush,
  output logic              o_mem_err,
  output logic [WIDTH-1:0]  o_stall_cycles
);

  logic        w_macc, w_lu, w_freeze;
  logic        w_pc_en, w_exmem_en;
  stage_ctrl_t w_ifid, w_idex, w_memwb;
  logic [WIDTH-1:0] r_stall_cycles;

  assign w_macc = i_mem_memwrite | i_mem_memtoreg;
  assign w_lu   = i_ex_memtoreg & i_ex_regwrite & (i_ex_ard != REG_X0) &
                  ((i_ex_ard == i_id_ars1) | (i_ex_ard == i_id_ars2));

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk          (clk),
    .rst          (rst),
    .i_macc       (w_macc),
    .i_dmem_ready (i_dmem_ready),
    .o_dmem_req   (o_dmem_req),
    .o_freeze     (w_freeze),
    .o_mem_err    (o_mem_err)
  );

  always_comb begin
    w_pc_en    = 1'b1;
    w_exmem_en = 1'b1;
    w_ifid     = '{en: 1'b1, flush: 1'b0};
    w_idex     = '{en: 1'b1, flush: 1'b0};
    w_memwb    = '{en: 1'b1, flush: 1'b0};
    if (!rst) begin
      // Reset holds the pass-through defaults.
    end else if (w_freeze) begin
      w_pc_en     = 1'b0;
      w_exmem_en  = 1'b0;
      w_ifid.en   = 1'b0;
      w_idex.en   = 1'b0;
      w_memwb.en  = 1'b0;
      w_memwb.flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      w_ifid.flush = 1'b1;
      w_idex.flush = 1'b1;
    end else if (w_lu) begin
      w_pc_en      = 1'b0;
      w_ifid.en    = 1'b0;
      w_idex.flush = 1'b1;
    end
  end

  assign o_pc_en       = w_pc_en;
  assign o_ifid_en     = w_ifid.en;
  assign o_idex_en     = w_idex.en;
  assign o_exmem_en    = w_exmem_en;
  assign o_memwb_en    = w_memwb.en;
  assign o_ifid_flush  = w_ifid.flush;
  assign o_idex_flush  = w_idex.flush;
  assign o_memwb_flush = w_memwb.flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_en && (r_stall_cycles != {WIDTH{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + WIDTH'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WIDTH=4, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] i_id_ars1, i_id_ars2, i_ex_ard;
  logic       i_ex_memtoreg, i_ex_regwrite, i_ex_branch_taken;
  logic       i_mem_memwrite, i_mem_memtoreg, i_dmem_ready;
  logic       o_dmem_req, o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
  logic       o_ifid_flush, o_idex_flush, o_memwb_flush, o_mem_err;
  logic [3:0] o_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed control vector: {pc,ifid,idex,exmem,memwb en, ifid,idex,memwb flush, dmem_req}
  logic [8:0] ctl;
  assign ctl = {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
                o_ifid_flush, o_idex_flush, o_memwb_flush, o_dmem_req};

  localparam logic [8:0] C_NONE   = 9'b11111_000_0;
  localparam logic [8:0] C_LU     = 9'b00111_010_0;
  localparam logic [8:0] C_BR     = 9'b11111_110_0;
  localparam logic [8:0] C_FRZ    = 9'b00000_001_1;
  localparam logic [8:0] C_REL    = 9'b11111_000_1;
  localparam logic [8:0] C_REL_BR = 9'b11111_110_1;

  pipe_hazard_ctrl #(.WIDTH(4), .MEM_TIMEOUT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_id_ars1         (i_id_ars1),
    .i_id_ars2         (i_id_ars2),
    .i_ex_ard          (i_ex_ard),
    .i_ex_memtoreg     (i_ex_memtoreg),
    .i_ex_regwrite     (i_ex_regwrite),
    .i_ex_branch_taken (i_ex_branch_taken),
    .i_mem_memwrite    (i_mem_memwrite),
    .i_mem_memtoreg    (i_mem_memtoreg),
    .i_dmem_ready      (i_dmem_ready),
    .o_dmem_req        (o_dmem_req),
    .o_pc_en           (o_pc_en),
    .o_ifid_en         (o_ifid_en),
    .o_idex_en         (o_idex_en),
    .o_exmem_en        (o_exmem_en),
    .o_memwb_en        (o_memwb_en),
    .o_ifid_flush      (o_ifid_flush),
    .o_idex_flush      (o_idex_flush),
    .o_memwb_flush     (o_memwb_flush),
    .o_mem_err         (o_mem_err),
    .o_stall_cycles    (o_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_id_ars1 = 5'd0; i_id_ars2 = 5'd0; i_ex_ard = 5'd0;
    i_ex_memtoreg = 1'b0; i_ex_regwrite = 1'b0; i_ex_branch_taken = 1'b0;
    i_mem_memwrite = 1'b0; i_mem_memtoreg = 1'b0; i_dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    // Every hazard source active while held in reset
    i_id_ars1 = 5'd3; i_ex_ard = 5'd3; i_ex_memtoreg = 1'b1; i_ex_regwrite = 1'b1;
    i_ex_branch_taken = 1'b1; i_mem_memtoreg = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); n_fail++; end
    step(); step();
    n_tests++;
    if (o_mem_err !== 1'b0) begin $display("FAIL reset_err got %b want 0", o_mem_err); n_fail++; end
    n_tests++;
    if (o_stall_cycles !== 4'd0) begin $display("FAIL reset_stall got %0d want 0", o_stall_cycles); n_fail++; end
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    i_id_ars1 = 5'd5; i_ex_ard = 5'd5; i_ex_memtoreg = 1'b1; i_ex_regwrite = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_LU) begin $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); n_fail++; end
    step();
    // Load advanced to MEM, bubble now in EX
    i_ex_memtoreg = 1'b0; i_ex_regwrite = 1'b0; i_ex_ard = 5'd0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin $display("FAIL lu_after got %b want %b", ctl, C_NONE); n_fail++; end
    n_tests++;
    if (o_stall_cycles !== 4'd1) begin $display("FAIL lu_stall got %0d want 1", o_stall_cycles); n_fail++; end
    i_id_ars1 = 5'd0; i_ex_ard = 5'd0; i_ex_memtoreg = 1'b1; i_ex_regwrite = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin $display("FAIL lu_x0 got %b want %b", ctl, C_NONE); n_fail++; end
    i_id_ars1 = 5'd1; i_id_ars2 = 5'd7; i_ex_ard = 5'd7;
    #1;
    n_tests++;
    if (ctl !== C_LU) begin $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); n_fail++; end
    i_ex_regwrite = 1'b0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin $display("FAIL lu_noregwr got %b want %b", ctl, C_NONE); n_fail++; end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_branch();
    do_reset();
    i_id_ars1 = 5'd9; i_ex_ard = 5'd9; i_ex_memtoreg = 1'b1; i_ex_regwrite = 1'b1;
    i_ex_branch_taken = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_BR) begin $display("FAIL branch_ctl got %b want %b", ctl, C_BR); n_fail++; end
    step();
    n_tests++;
    if (o_stall_cycles !== 4'd0) begin $display("FAIL branch_stall got %0d want 0", o_stall_cycles); n_fail++; end
    $display("[TB] test_branch done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    i_mem_memtoreg = 1'b1; i_dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_FRZ) begin $display("FAIL wait_frz%0d got %b want %b", i, ctl, C_FRZ); n_fail++; end
      step();
    end
    i_dmem_ready = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_REL) begin $display("FAIL wait_rel got %b want %b", ctl, C_REL); n_fail++; end
    n_tests++;
    if (o_stall_cycles !== 4'd3) begin $display("FAIL wait_stall got %0d want 3", o_stall_cycles); n_fail++; end
    step();
    // Zero-wait access: ready in its first cycle, no freeze
    i_mem_memtoreg = 1'b0; i_mem_memwrite = 1'b1; i_dmem_ready = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_REL) begin $display("FAIL zero_wait got %b want %b", ctl, C_REL); n_fail++; end
    step();
    i_mem_memwrite = 1'b0; i_dmem_ready = 1'b0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin $display("FAIL wait_idle got %b want %b", ctl, C_NONE); n_fail++; end
    n_tests++;
    if ({o_stall_cycles, o_mem_err} !== {4'd3, 1'b0}) begin
      $display("FAIL wait_final got stall=%0d err=%b want stall=3 err=0", o_stall_cycles, o_mem_err); n_fail++;
    end
    $display("[TB] test_mem_wait done");
  endtask

  task automatic test_timeout();
    do_reset();
    i_mem_memwrite = 1'b1; i_dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_FRZ) begin $display("FAIL tmo_frz%0d got %b want %b", i, ctl, C_FRZ); n_fail++; end
      step();
    end
    #1;
    n_tests++;
    if (ctl !== C_REL) begin $display("FAIL tmo_rel got %b want %b", ctl, C_REL); n_fail++; end
    n_tests++;
    if (o_mem_err !== 1'b0) begin $display("FAIL tmo_err_early got %b want 0", o_mem_err); n_fail++; end
    step();
    i_mem_memwrite = 1'b0;
    n_tests++;
    if (o_mem_err !== 1'b1) begin $display("FAIL tmo_err_set got %b want 1", o_mem_err); n_fail++; end
    step(); step(); step();
    n_tests++;
    if ({o_mem_err, o_stall_cycles} !== {1'b1, 4'd3}) begin
      $display("FAIL tmo_sticky got err=%b stall=%0d want err=1 stall=3", o_mem_err, o_stall_cycles); n_fail++;
    end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_freeze_branch();
    do_reset();
    i_mem_memtoreg = 1'b1; i_dmem_ready = 1'b0; i_ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_FRZ) begin $display("FAIL frzbr_frz%0d got %b want %b", i, ctl, C_FRZ); n_fail++; end
      step();
    end
    i_dmem_ready = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_REL_BR) begin $display("FAIL frzbr_rel got %b want %b", ctl, C_REL_BR); n_fail++; end
    step();
    $display("[TB] test_freeze_branch done");
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    i_mem_memwrite = 1'b1; i_dmem_ready = 1'b0;
    // Time out once (err set), then re-enter MEM_WAIT with access still pending
    step(); step(); step(); step(); step();
    n_tests++;
    if (o_mem_err !== 1'b1) begin $display("FAIL midrst_err_pre got %b want 1", o_mem_err); n_fail++; end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin $display("FAIL midrst_ctl got %b want %b", ctl, C_NONE); n_fail++; end
    step();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_mem_err, o_stall_cycles} !== {1'b0, 4'd0}) begin
      $display("FAIL midrst_regs got err=%b stall=%0d want err=0 stall=0", o_mem_err, o_stall_cycles); n_fail++;
    end
    // Fresh wait must give the full three frozen cycles before forced release
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_FRZ) begin $display("FAIL midrst_frz%0d got %b want %b", i, ctl, C_FRZ); n_fail++; end
      step();
    end
    #1;
    n_tests++;
    if (ctl !== C_REL) begin $display("FAIL midrst_rel got %b want %b", ctl, C_REL); n_fail++; end
    step();
    i_mem_memwrite = 1'b0;
    $display("[TB] test_reset_mid_wait done");
  endtask

  task automatic test_saturation();
    do_reset();
    i_id_ars1 = 5'd4; i_ex_ard = 5'd4; i_ex_memtoreg = 1'b1; i_ex_regwrite = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        n_tests++;
        if (o_stall_cycles !== 4'hE) begin $display("FAIL sat_14 got %h want e", o_stall_cycles); n_fail++; end
      end
    end
    n_tests++;
    if (o_stall_cycles !== 4'hF) begin $display("FAIL sat_hold got %h want f", o_stall_cycles); n_fail++; end
    clear_inputs();
    $display("[TB] test_saturation done");
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_freeze_branch();
    test_reset_mid_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
